binary_search_engine: RTL and testbench

Self-sequencing, parametrised binary search over an externally owned, ascending-sorted synchronous-read memory. Takes a target through a start/done handshake and reports found, not found, match address and iteration count. Successor to the fixed 32x8 search datapath: owns its own FSM, tolerates configurable RAM read latency, and has no pointer underflow or overflow at the array ends. Sits between the top-level UI (switch and key input, HEX display output) and the lookup RAM.

---
 rtl/binary_search_engine.sv | 176 +++++++++++++++++
 tb/tb_binary_search_engine.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_search_engine.sv
// Binary search over an external ascending-sorted synchronous-read RAM with a start/done handshake.
// Optional build macro BSEARCH_LOWER_BOUND_EN: on a miss, result_addr reports the insertion index.
module binary_search_engine #(
    parameter int VAL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2 ** ADDR_WIDTH,
    parameter int RD_LAT     = 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [VAL_WIDTH-1:0]            target,
    output logic                            busy,
    output logic                            done,
    output logic                            found,
    output logic                            not_found,
    output logic [ADDR_WIDTH:0]             result_addr,
    output logic [$clog2(ADDR_WIDTH+2)-1:0] iterations,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic                            mem_rd,
    input  logic [VAL_WIDTH-1:0]            mem_data
);
    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int IT_W  = $clog2(ADDR_WIDTH + 2);
    localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     l_q, l_d;
    logic [PTR_W-1:0]     r_q, r_d;
    logic [VAL_WIDTH-1:0] target_q, target_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 found_q, found_d;
    logic                 not_found_q, not_found_d;
    logic [PTR_W-1:0]     result_addr_q, result_addr_d;
    logic [IT_W-1:0]      iterations_q, iterations_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                 mem_rd_q, mem_rd_d;
    logic [PTR_W-1:0]     mid_ext;

    // mem_addr_q holds the current midpoint for the whole iteration.
    assign mid_ext = {1'b0, mem_addr_q};

    always_comb begin
        state_d       = state_q;
        l_d           = l_q;
        r_d           = r_q;
        target_d      = target_q;
        wait_cnt_d    = wait_cnt_q;
        found_d       = found_q;
        not_found_d   = not_found_q;
        result_addr_d = result_addr_q;
        iterations_d  = iterations_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_ISSUE;
                    l_d           = '0;
                    r_d           = PTR_W'(DEPTH);
                    target_d      = target;
                    found_d       = 1'b0;
                    not_found_d   = 1'b0;
                    result_addr_d = '0;
                    iterations_d  = '0;
                end
            end
            S_ISSUE: begin
                if (RD_LAT > 1) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = CNT_W'(RD_LAT - 2);
                end else begin
                    state_d = S_COMPARE;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = S_COMPARE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            S_COMPARE: begin
                iterations_d = iterations_q + 1'b1;
                if (mem_data == target_q) begin
                    found_d       = 1'b1;
                    result_addr_d = mid_ext;
                    state_d       = S_DONE;
                end else begin
                    if (mem_data < target_q) begin
                        l_d = mid_ext + 1'b1;
                    end else begin
                        r_d = mid_ext;
                    end
                    if (l_d == r_d) begin
                        not_found_d = 1'b1;
`ifdef BSEARCH_LOWER_BOUND_EN
                        result_addr_d = l_d;
`else
                        result_addr_d = '0;
`endif
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Sum is one bit wider than L/R so L+R=2*DEPTH cannot wrap.
        if (state_d == S_ISSUE) begin
            mem_addr_d = ADDR_WIDTH'(({1'b0, l_d} + {1'b0, r_d}) >> 1);
            mem_rd_d   = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            l_q           <= '0;
            r_q           <= '0;
            target_q      <= '0;
            wait_cnt_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            not_found_q   <= 1'b0;
            result_addr_q <= '0;
            iterations_q  <= '0;
            mem_addr_q    <= '0;
            mem_rd_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            l_q           <= l_d;
            r_q           <= r_d;
            target_q      <= target_d;
            wait_cnt_q    <= wait_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            found_q       <= found_d;
            not_found_q   <= not_found_d;
            result_addr_q <= result_addr_d;
            iterations_q  <= iterations_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_q      <= mem_rd_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign not_found   = not_found_q;
    assign result_addr = result_addr_q;
    assign iterations  = iterations_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
endmodule

// File: tb/tb_binary_search_engine.sv
// Scoreboard bench: two engines (read latency 1 and 3) over a RAM holding mem[i]=2i+1.
module tb_binary_search_engine;
    localparam int AW = 5;
    localparam int VW = 8;
    localparam int IW = 3;
`ifdef BSEARCH_LOWER_BOUND_EN
    localparam int LB = 1;
`else
    localparam int LB = 0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic          start_a, busy_a, done_a, found_a, nf_a, mrd_a;
    logic [VW-1:0] target_a, mdata_a;
    logic [AW:0]   res_a;
    logic [IW-1:0] it_a;
    logic [AW-1:0] maddr_a;

    logic          start_b, busy_b, done_b, found_b, nf_b, mrd_b;
    logic [VW-1:0] target_b, mdata_b;
    logic [AW:0]   res_b;
    logic [IW-1:0] it_b;
    logic [AW-1:0] maddr_b;

    binary_search_engine #(.VAL_WIDTH(VW), .ADDR_WIDTH(AW), .DEPTH(32), .RD_LAT(1)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .target(target_a),
        .busy(busy_a), .done(done_a), .found(found_a), .not_found(nf_a),
        .result_addr(res_a), .iterations(it_a), .mem_addr(maddr_a),
        .mem_rd(mrd_a), .mem_data(mdata_a));

    binary_search_engine #(.VAL_WIDTH(VW), .ADDR_WIDTH(AW), .DEPTH(32), .RD_LAT(3)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .target(target_b),
        .busy(busy_b), .done(done_b), .found(found_b), .not_found(nf_b),
        .result_addr(res_b), .iterations(it_b), .mem_addr(maddr_b),
        .mem_rd(mrd_b), .mem_data(mdata_b));

    function automatic logic [VW-1:0] mem_val(input logic [AW-1:0] a);
        return VW'(2 * int'(a) + 1);
    endfunction

    // RAM models: data appears RD_LAT cycles after the address is sampled.
    always @(posedge clock) mdata_a <= mem_val(maddr_a);
    logic [VW-1:0] pipe_b [3];
    always @(posedge clock) begin
        pipe_b[0] <= mem_val(maddr_b);
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign mdata_b = pipe_b[2];

    typedef struct {
        int               tgt;
        logic             found;
        logic             nf;
        int               res;
        int               it;
        int               lat;
        int               naddr;
        logic [7:0][AW-1:0] addrs;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int tgt, input logic f, input logic nf, input int res,
                                input int it, input int lat, input int n,
                                input int a0, input int a1, input int a2,
                                input int a3, input int a4, input int a5);
        exp_t e;
        e.tgt = tgt; e.found = f; e.nf = nf; e.res = res; e.it = it; e.lat = lat; e.naddr = n;
        e.addrs = '0;
        e.addrs[0] = AW'(a0); e.addrs[1] = AW'(a1); e.addrs[2] = AW'(a2);
        e.addrs[3] = AW'(a3); e.addrs[4] = AW'(a4); e.addrs[5] = AW'(a5);
        return e;
    endfunction

    task automatic check_done(input string tag, input exp_t e, input logic f, input logic nf,
                              input logic [AW:0] r, input logic [IW-1:0] it, input int lat,
                              input logic bsy, input int n, input logic [7:0][AW-1:0] s);
        $display("%s target=%0d found=%0d not_found=%0d result_addr=%0d iterations=%0d cycles=%0d",
                 tag, e.tgt, f, nf, r, it, lat);
        chk($sformatf("%s[%0d].found", tag, e.tgt), int'(f), int'(e.found));
        chk($sformatf("%s[%0d].not_found", tag, e.tgt), int'(nf), int'(e.nf));
        chk($sformatf("%s[%0d].exclusive", tag, e.tgt), int'(f & nf), 0);
        chk($sformatf("%s[%0d].result_addr", tag, e.tgt), int'(r), e.res);
        chk($sformatf("%s[%0d].iterations", tag, e.tgt), int'(it), e.it);
        chk($sformatf("%s[%0d].done_cycle", tag, e.tgt), lat, e.lat);
        chk($sformatf("%s[%0d].busy_in_done", tag, e.tgt), int'(bsy), 1);
        chk($sformatf("%s[%0d].num_reads", tag, e.tgt), n, e.naddr);
        for (int i = 0; i < e.naddr && i < 8; i++)
            chk($sformatf("%s[%0d].mem_addr%0d", tag, e.tgt, i), int'(s[i]), int'(e.addrs[i]));
    endtask

    // Monitors: acceptance is seen as start&&!busy; done pops the scoreboard.
    int cyc_a = 0, acc_a = 0, n_a = 0;
    logic [7:0][AW-1:0] s_a;
    always @(negedge clock) begin
        cyc_a++;
        if (!reset) begin
            if (start_a && !busy_a) begin
                acc_a = cyc_a;
                n_a = 0;
                s_a = '0;
            end
            if (mrd_a) begin
                if (n_a < 8) s_a[n_a] = maddr_a;
                n_a++;
            end
            if (done_a) begin
                if (q_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL a.spurious_done: got done=1 expected done=0");
                end else begin
                    e_a = q_a.pop_front();
                    check_done("a", e_a, found_a, nf_a, res_a, it_a, cyc_a - acc_a, busy_a, n_a, s_a);
                end
            end
        end
    end

    int cyc_b = 0, acc_b = 0, n_b = 0;
    logic [7:0][AW-1:0] s_b;
    always @(negedge clock) begin
        cyc_b++;
        if (!reset) begin
            if (start_b && !busy_b) begin
                acc_b = cyc_b;
                n_b = 0;
                s_b = '0;
            end
            if (mrd_b) begin
                if (n_b < 8) s_b[n_b] = maddr_b;
                n_b++;
            end
            if (done_b) begin
                if (q_b.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b.spurious_done: got done=1 expected done=0");
                end else begin
                    e_b = q_b.pop_front();
                    check_done("b", e_b, found_b, nf_b, res_b, it_b, cyc_b - acc_b, busy_b, n_b, s_b);
                end
            end
        end
    end

    task automatic search_a(input int t, input exp_t e);
        @(posedge clock); #1;
        start_a = 1'b1; target_a = VW'(t); q_a.push_back(e);
        @(posedge clock); #1;
        start_a = 1'b0;
    endtask

    task automatic search_b(input int t, input exp_t e);
        @(posedge clock); #1;
        start_b = 1'b1; target_b = VW'(t); q_b.push_back(e);
        @(posedge clock); #1;
        start_b = 1'b0;
    endtask

    task automatic wait_a();
        int n = 0;
        while (q_a.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("a.timeout_pending", q_a.size(), 0);
        q_a.delete();
    endtask

    task automatic wait_b();
        int n = 0;
        while (q_b.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("b.timeout_pending", q_b.size(), 0);
        q_b.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start_a = 1'b0; target_a = '0;
        start_b = 1'b0; target_b = '0;
        repeat (2) @(negedge clock);
        chk("a.reset_state", int'({busy_a, done_a, found_a, nf_a, res_a, it_a, maddr_a, mrd_a}), 0);
        chk("b.reset_state", int'({busy_b, done_b, found_b, nf_b, res_b, it_b, maddr_b, mrd_b}), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Latency 1, directed vectors
        search_a(51, mk(51, 1, 0, 25, 5, 11, 5, 16, 24, 28, 26, 25, 0)); wait_a();
        search_a(0,  mk(0,  0, 1, 0,  6, 13, 6, 16, 8, 4, 2, 1, 0));     wait_a();
        search_a(64, mk(64, 0, 1, LB ? 32 : 0, 5, 11, 5, 16, 24, 28, 30, 31, 0)); wait_a();
        search_a(52, mk(52, 0, 1, LB ? 26 : 0, 5, 11, 5, 16, 24, 28, 26, 25, 0)); wait_a();
        search_a(63, mk(63, 1, 0, 31, 5, 11, 5, 16, 24, 28, 30, 31, 0)); wait_a();

        // Results hold after done
        repeat (3) @(negedge clock);
        chk("a.hold_found", int'(found_a), 1);
        chk("a.hold_result_addr", int'(res_a), 31);

        // Start held high: ignored in DONE, taken in the following IDLE
        @(posedge clock); #1;
        start_a = 1'b1; target_a = 8'd1;
        q_a.push_back(mk(1, 1, 0, 0, 6, 13, 6, 16, 8, 4, 2, 1, 0));
        for (int n = 0; n < 100 && !done_a; n++) @(negedge clock);
        target_a = 8'd51;
        q_a.push_back(mk(51, 1, 0, 25, 5, 11, 5, 16, 24, 28, 26, 25, 0));
        @(posedge clock);
        @(posedge clock); #1;
        start_a = 1'b0;
        wait_a();

        // Latency 3, with a start pulse mid-search
        @(posedge clock); #1;
        start_b = 1'b1; target_b = 8'd51;
        q_b.push_back(mk(51, 1, 0, 25, 5, 21, 5, 16, 24, 28, 26, 25, 0));
        @(posedge clock); #1;
        start_b = 1'b0;
        repeat (4) @(posedge clock); #1;
        start_b = 1'b1; target_b = 8'd3;
        @(posedge clock); #1;
        start_b = 1'b0; target_b = '0;
        wait_b();
        search_b(0,  mk(0,  0, 1, 0, 6, 25, 6, 16, 8, 4, 2, 1, 0)); wait_b();
        search_b(64, mk(64, 0, 1, LB ? 32 : 0, 5, 21, 5, 16, 24, 28, 30, 31, 0)); wait_b();

        // Reset during the third iteration of a latency-1 search
        @(posedge clock); #1;
        start_a = 1'b1; target_a = 8'd51;
        @(posedge clock); #1;
        start_a = 1'b0;
        repeat (4) @(posedge clock); #1;
        chk("a.pre_reset_iterations", int'(it_a), 2);
        reset = 1'b1;
        @(negedge clock);
        chk("a.mid_reset_outputs", int'({busy_a, done_a, found_a, nf_a, res_a, it_a, maddr_a, mrd_a}), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("a.idle_after_reset", int'(busy_a), 0);
        search_a(1, mk(1, 1, 0, 0, 6, 13, 6, 16, 8, 4, 2, 1, 0)); wait_a();

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
